eth_tx_arbiter: RTL

ETH_TX_ARBITER -- requirements
Module: eth_tx_arbiter

---
 rtl/eth_tx_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: two-requester round-robin arbiter in front of a shared
// Ethernet frame generator. It owns the IDLE/START/ACTIVE/IPG sequencing,
// the inter-packet gap timing and the payload stream multiplexing.
//
// Optional feature: define ETH_TX_ARBITER_STATS_EN to get per-requester
// 16-bit completed-frame counters on frames0/frames1. Without it the ports
// are still present and are tied to zero.
module eth_tx_arbiter #(
    parameter int IPG_DIBITS = 48,
    parameter int BYTE_LEN   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    output logic [1:0]          grant,
    input  logic [BYTE_LEN-1:0] in0,
    input  logic [BYTE_LEN-1:0] in1,
    input  logic                inclk0,
    input  logic                inclk1,
    input  logic                in_done0,
    input  logic                in_done1,
    output logic                upstream_readclk0,
    output logic                upstream_readclk1,
    output logic                gen_start,
    output logic [BYTE_LEN-1:0] gen_in,
    output logic                gen_inclk,
    output logic                gen_in_done,
    input  logic                gen_upstream_readclk,
    input  logic                gen_done,
    output logic                busy,
    output logic [15:0]         frames0,
    output logic [15:0]         frames1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        ACTIVE = 2'd2,
        IPG    = 2'd3
    } state_e;

    // Counter reload value: the gap counter counts down to zero, so the
    // last IPG cycle is the one where it reads zero.
    localparam int         IPG_M1   = (IPG_DIBITS > 0) ? (IPG_DIBITS - 1) : 0;
    localparam logic [7:0] IPG_LOAD = 8'(IPG_M1);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       gen_start_q, gen_start_d;
    logic       busy_q, busy_d;
    logic [7:0] ipg_cnt_q, ipg_cnt_d;
    logic       last_q, last_d;   // index of the requester granted most recently
    logic [1:0] pick_s;

    // Round-robin choice: with both requesting, favour the one not served last.
    function automatic logic [1:0] rr_pick(input logic [1:0] r, input logic last);
        logic [1:0] g;
        case (r)
            2'b01:   g = 2'b01;
            2'b10:   g = 2'b10;
            2'b11:   g = last ? 2'b01 : 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // Candidate grant for whenever an arbitration point is reached.
    always_comb begin
        pick_s = rr_pick(req, last_q);
    end

    // Next-state, grant and gap-counter logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ipg_cnt_d = ipg_cnt_q;
        last_d    = last_q;
        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_d = pick_s;
                    last_d  = pick_s[1];
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = ACTIVE;
            end
            ACTIVE: begin
                if (gen_done) begin
                    grant_d = 2'b00;
                    if (IPG_DIBITS == 0) begin
                        // No gap: arbitrate straight away, as IDLE would.
                        if (req != 2'b00) begin
                            grant_d = pick_s;
                            last_d  = pick_s[1];
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        ipg_cnt_d = IPG_LOAD;
                        state_d   = IPG;
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            IPG: begin
                if (ipg_cnt_q == 8'd0) begin
                    if (req != 2'b00) begin
                        grant_d = pick_s;
                        last_d  = pick_s[1];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    ipg_cnt_d = ipg_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
        gen_start_d = (state_d == START);
        busy_d      = (state_d != IDLE);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            gen_start_q <= 1'b0;
            busy_q      <= 1'b0;
            ipg_cnt_q   <= 8'd0;
            last_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gen_start_q <= gen_start_d;
            busy_q      <= busy_d;
            ipg_cnt_q   <= ipg_cnt_d;
            last_q      <= last_d;
        end
    end

    assign grant     = grant_q;
    assign gen_start = gen_start_q;
    assign busy      = busy_q;

    // Zero-latency payload mux from the current owner; nothing when unowned.
    always_comb begin
        gen_in      = {BYTE_LEN{1'b0}};
        gen_inclk   = 1'b0;
        gen_in_done = 1'b0;
        case (grant_q)
            2'b01: begin
                gen_in      = in0;
                gen_inclk   = inclk0;
                gen_in_done = in_done0;
            end
            2'b10: begin
                gen_in      = in1;
                gen_inclk   = inclk1;
                gen_in_done = in_done1;
            end
            default: begin
                gen_in      = {BYTE_LEN{1'b0}};
                gen_inclk   = 1'b0;
                gen_in_done = 1'b0;
            end
        endcase
    end

    assign upstream_readclk0 = gen_upstream_readclk & grant_q[0];
    assign upstream_readclk1 = gen_upstream_readclk & grant_q[1];

`ifdef ETH_TX_ARBITER_STATS_EN
    logic [15:0] frames0_q, frames0_d;
    logic [15:0] frames1_q, frames1_d;
    logic        frame_end_s;

    // Count a frame when the generator finishes while a requester owns it.
    always_comb begin
        frame_end_s = (state_q == ACTIVE) && gen_done;
        frames0_d   = frames0_q;
        frames1_d   = frames1_q;
        if (frame_end_s && grant_q[0]) begin
            frames0_d = frames0_q + 16'd1;
        end else begin
            frames0_d = frames0_q;
        end
        if (frame_end_s && grant_q[1]) begin
            frames1_d = frames1_q + 16'd1;
        end else begin
            frames1_d = frames1_q;
        end
    end

    // Frame counter registers, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames0_q <= 16'd0;
            frames1_q <= 16'd0;
        end else begin
            frames0_q <= frames0_d;
            frames1_q <= frames1_d;
        end
    end

    assign frames0 = frames0_q;
    assign frames1 = frames1_q;
`else
    assign frames0 = 16'd0;
    assign frames1 = 16'd0;
`endif

endmodule
